// File: rtl/pu_msp430_trace_pkg.sv
// rtl/pu_msp430_trace_pkg.sv - shared types and constants for the MSP430 instruction trace recorder
package pu_msp430_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } trc_state_t;

    // The record head; the cycle count of width CYC_W is appended below PC_OFF in each entry.
    typedef struct packed {
        logic        irq;
        logic [15:0] op;
        logic [15:0] pc;
    } trc_rec_t;

    localparam int REC_W   = 33;
    localparam int PC_OFF  = 0;
    localparam int OP_OFF  = 16;
    localparam int IRQ_OFF = 32;

    localparam logic [15:0] DRP_MAX = 16'hFFFF;

endpackage

// File: rtl/pu_msp430_trace_fifo.sv
// rtl/pu_msp430_trace_fifo.sv - first-word-fall-through trace buffer with optional overwrite of oldest entry
module pu_msp430_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 41
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    input  logic                   overwrite_en,
    output logic [W-1:0]           rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          we;
    logic          empty;
    logic          is_full;
    logic          do_pop;

    assign empty   = (cnt_q == '0);
    assign is_full = (cnt_q == FULL_CNT);
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        drop     = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                if (is_full && !do_pop) begin
                    drop = 1'b1;
                    // Overwrite: write and read pointers coincide when full, so both advance together.
                    if (overwrite_en) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (!do_pop) cnt_d = cnt_q + 1'b1;
                end
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (!push) cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign valid = ~empty;
    assign level = cnt_q;
    assign full  = is_full;

endmodule

// File: rtl/pu_msp430_trace.sv
// rtl/pu_msp430_trace.sv - MSP430 instruction trace recorder: capture FSM, pending record, counters
module pu_msp430_trace
    import pu_msp430_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYC_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                     mclk,
    input  logic                     puc_rst_n,
    input  logic                     decode,
    input  logic [15:0]              ir,
    input  logic [15:0]              pc,
    input  logic                     irq_detect,
    input  logic [3:0]               irq_num,
    input  logic                     trc_en,
    input  logic                     trc_wrap,
    input  logic                     trc_clr,
    input  logic                     trig_en,
    input  logic [15:0]              trig_pc,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [REC_W+CYC_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [15:0]              drop_cnt,
    output logic [CNT_W-1:0]         inst_number,
    output logic [1:0]               state
);
    localparam int ENT_W = REC_W + CYC_W;

    trc_state_t       state_q, state_d;
    trc_rec_t         pend_q, pend_d;
    trc_rec_t         cur_rec;
    logic             pend_vld_q, pend_vld_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] inst_q, inst_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             trig_hit;
    logic             capture;
    logic             push;
    logic             fifo_drop;

    always_comb begin
        trig_hit = decode && (pc == trig_pc);
        capture  = trc_en && decode && ((state_q == CAPTURE) || (state_q == ARMED && trig_hit));
        push     = trc_en && decode && (state_q == CAPTURE) && pend_vld_q;
        cur_rec  = {irq_detect, irq_detect ? {12'h000, irq_num} : ir, pc};

        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        inst_d     = decode ? inst_q + 1'b1 : inst_q;
        cyc_d      = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        drop_cnt_d = (fifo_drop && drop_cnt_q != DRP_MAX) ? drop_cnt_q + 1'b1 : drop_cnt_q;

        if (capture) begin
            pend_d     = cur_rec;
            pend_vld_d = 1'b1;
            cyc_d      = {{(CYC_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            IDLE: begin
                if (trc_en) state_d = trig_en ? ARMED : CAPTURE;
            end
            ARMED: begin
                if (!trc_en)       state_d = IDLE;
                else if (trig_hit) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!trc_en) begin
                    state_d    = IDLE;
                    pend_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (trc_clr) begin
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            inst_d     = '0;
            drop_cnt_d = '0;
            cyc_d      = '0;
        end
    end

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cyc_q      <= '0;
            inst_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    pu_msp430_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk          (mclk),
        .resetn       (puc_rst_n),
        .clr          (trc_clr),
        .push         (push),
        .wdata        ({pend_q, cyc_q}),
        .pop          (rd_ready),
        .overwrite_en (trc_wrap),
        .rdata        (rd_data),
        .valid        (rd_valid),
        .level        (level),
        .full         (full),
        .drop         (fifo_drop)
    );

    assign drop_cnt    = drop_cnt_q;
    assign inst_number = inst_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pu_msp430_trace.sv
// tb/tb_pu_msp430_trace.sv - scoreboard bench for the trace recorder (DEPTH=4, CYC_W=4)
module tb_pu_msp430_trace;
    localparam int DEPTH = 4;
    localparam int CYC_W = 4;
    localparam int CNT_W = 32;
    localparam int ENT_W = 33 + CYC_W;

    logic              mclk;
    logic              puc_rst_n;
    logic              decode;
    logic [15:0]       ir;
    logic [15:0]       pc;
    logic              irq_detect;
    logic [3:0]        irq_num;
    logic              trc_en;
    logic              trc_wrap;
    logic              trc_clr;
    logic              trig_en;
    logic [15:0]       trig_pc;
    logic              rd_ready;
    logic              rd_valid;
    logic [ENT_W-1:0]  rd_data;
    logic [2:0]        level;
    logic              full;
    logic [15:0]       drop_cnt;
    logic [CNT_W-1:0]  inst_number;
    logic [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ENT_W-1:0] exp_q[$];

    pu_msp430_trace #(.DEPTH(DEPTH), .CYC_W(CYC_W), .CNT_W(CNT_W)) dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .decode      (decode),
        .ir          (ir),
        .pc          (pc),
        .irq_detect  (irq_detect),
        .irq_num     (irq_num),
        .trc_en      (trc_en),
        .trc_wrap    (trc_wrap),
        .trc_clr     (trc_clr),
        .trig_en     (trig_en),
        .trig_pc     (trig_pc),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .level       (level),
        .full        (full),
        .drop_cnt    (drop_cnt),
        .inst_number (inst_number),
        .state       (state)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [ENT_W-1:0] ent(input logic irq, input logic [15:0] op,
                                             input logic [15:0] p, input logic [CYC_W-1:0] c);
        return {irq, op, p, c};
    endfunction

    always @(negedge mclk) begin
        if (puc_rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_entry", {27'h0, rd_data}, 64'h0);
            end else begin
                chk("sb_entry", {27'h0, rd_data}, {27'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic dec(input logic [15:0] p, input logic [15:0] op,
                       input logic irqd = 1'b0, input logic [3:0] num = 4'h0);
        decode = 1'b1; pc = p; ir = op; irq_detect = irqd; irq_num = num;
        step(1);
        decode = 1'b0; irq_detect = 1'b0;
    endtask

    task automatic drain(input string nm);
        rd_ready = 1'b1;
        for (int i = 0; i < 16 && rd_valid; i++) step(1);
        rd_ready = 1'b0;
        chk({nm, "_drained"}, rd_valid, 0);
    endtask

    task automatic clear();
        trc_clr = 1'b1;
        step(1);
        trc_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        puc_rst_n = 1'b0; decode = 1'b0; ir = '0; pc = '0; irq_detect = 1'b0; irq_num = '0;
        trc_en = 1'b0; trc_wrap = 1'b0; trc_clr = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;

        // Reset with inputs toggling
        for (int i = 0; i < 5; i++) begin
            decode = 1'($urandom); ir = 16'($urandom); pc = 16'($urandom);
            irq_detect = 1'($urandom); irq_num = 4'($urandom); trc_en = 1'($urandom);
            trc_wrap = 1'($urandom); trig_en = 1'($urandom); trig_pc = 16'($urandom);
            step(1);
        end
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", {27'h0, rd_data}, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_inst_number", inst_number, 0);
        chk("rst_state", state, 0);

        decode = 1'b0; irq_detect = 1'b0; trc_en = 1'b0; trc_wrap = 1'b0; trig_en = 1'b0;
        puc_rst_n = 1'b1;
        step(1);
        dec(16'hE000, 16'h4303);
        dec(16'hE002, 16'h4303);
        dec(16'hE004, 16'h4303);
        chk("idle_inst_number", inst_number, 3);
        chk("idle_state", state, 0);
        chk("idle_level", level, 0);

        // Basic capture: decodes at t=0, 3, 4
        clear();
        chk("clr_inst_number", inst_number, 0);
        trc_en = 1'b1;
        step(1);
        chk("cap_state", state, 2);
        exp_q.push_back(ent(1'b0, 16'h4303, 16'hF000, 4'd3));
        exp_q.push_back(ent(1'b0, 16'h5405, 16'hF002, 4'd1));
        dec(16'hF000, 16'h4303);
        step(2);
        dec(16'hF002, 16'h5405);
        dec(16'hF004, 16'h4130);
        chk("cap_level", level, 2);
        chk("cap_inst_number", inst_number, 3);
        drain("cap");
        chk("cap_empty_rd_data", {27'h0, rd_data}, 0);
        trc_en = 1'b0;
        step(1);
        chk("cap_off_state", state, 0);

        // PC trigger
        clear();
        trig_en = 1'b1; trig_pc = 16'hF010; trc_en = 1'b1;
        step(1);
        chk("trig_armed0", state, 1);
        dec(16'hF000, 16'h4301);
        chk("trig_armed1", state, 1);
        dec(16'hF008, 16'h4302);
        chk("trig_armed2", state, 1);
        exp_q.push_back(ent(1'b0, 16'h4303, 16'hF010, 4'd1));
        dec(16'hF010, 16'h4303);
        chk("trig_capture", state, 2);
        dec(16'hF012, 16'h4304);
        chk("trig_level", level, 1);
        drain("trig");
        trc_en = 1'b0; trig_en = 1'b0;
        step(1);

        // Stop when full
        clear();
        trc_wrap = 1'b0; trc_en = 1'b1;
        step(1);
        for (int i = 1; i <= 4; i++)
            exp_q.push_back(ent(1'b0, 16'h1000 + 16'(i), 16'hF100 + 16'(2*i), 4'd1));
        for (int i = 1; i <= 7; i++) dec(16'hF100 + 16'(2*i), 16'h1000 + 16'(i));
        chk("stop_full", full, 1);
        chk("stop_level", level, 4);
        chk("stop_drop_cnt", drop_cnt, 2);
        trc_en = 1'b0;
        step(1);
        drain("stop");

        // Circular overwrite, then push and pop together while full
        clear();
        trc_wrap = 1'b1; trc_en = 1'b1;
        step(1);
        for (int i = 3; i <= 6; i++)
            exp_q.push_back(ent(1'b0, 16'h1000 + 16'(i), 16'hF100 + 16'(2*i), 4'd1));
        for (int i = 1; i <= 7; i++) dec(16'hF100 + 16'(2*i), 16'h1000 + 16'(i));
        chk("wrap_full", full, 1);
        chk("wrap_level", level, 4);
        chk("wrap_drop_cnt", drop_cnt, 2);
        exp_q.push_back(ent(1'b0, 16'h1007, 16'hF10E, 4'd1));
        rd_ready = 1'b1;
        dec(16'hF110, 16'h1008);
        chk("pushpop_level", level, 4);
        chk("pushpop_drop_cnt", drop_cnt, 2);
        trc_en = 1'b0;
        drain("wrap");
        trc_wrap = 1'b0;

        // IRQ record and cycle saturation at 15
        clear();
        trc_en = 1'b1;
        step(1);
        exp_q.push_back(ent(1'b1, 16'h0009, 16'hF100, 4'd3));
        exp_q.push_back(ent(1'b0, 16'h4031, 16'hF200, 4'd15));
        dec(16'hF100, 16'hABCD, 1'b1, 4'd9);
        step(2);
        dec(16'hF200, 16'h4031);
        step(19);
        dec(16'hF300, 16'h4032);
        chk("irq_level", level, 2);
        drain("irq");

        // Clear mid-capture
        dec(16'hF302, 16'h4033);
        chk("preclr_level", level, 1);
        clear();
        chk("clr_level", level, 0);
        chk("clr_drop_cnt", drop_cnt, 0);
        chk("clr_state", state, 0);
        chk("clr_inst", inst_number, 0);
        step(1);
        dec(16'hF400, 16'h4034);
        step(3);
        chk("postclr_level", level, 0);
        chk("postclr_valid", rd_valid, 0);
        chk("postclr_inst", inst_number, 1);
        trc_en = 1'b0;
        step(1);

        chk("sb_all_consumed", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
